mux_rr_sched: RTL and testbench
===============================

# mux_rr_sched

Round-robin scheduler that shares the 8-input, 8-bit registered output mux between eight requesters. It picks one requester per burst and drives the mux `Sel` and `Enable` lines. It also tracks burst length and backpressure, and qualifies the mux's registered output `Y` with `Out_Valid` for the downstream consumer. It sits beside the mux, and both share `Clock` and `Reset`.

## Interface
- `NUM_REQ`, 8: number of requesters. Fixed to the mux fan-in; any other value is unsupported.
- `SEL_W`, 3: select width, equal to clog2(`NUM_REQ`).
- `MAX_BURST`, 4: maximum beats per grant, legal range 1..15.
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high. Returns every register to its reset value on the next rising `Clock`.
- `Req` in 8: per-requester request, level-sensitive. Bit i means input Ii holds valid data.
- `Last` in 8: per-requester last-beat flag. Sampled only on a beat of the granted requester.
- `Out_Ready` in 1: downstream credit. High in cycle N guarantees the consumer accepts `Y` in cycle N+1.
- `Sel` out 3: mux select, registered.
- `Enable` out 1: mux load strobe, one beat.
- `Gnt` out 8: one-hot grant to requesters. Bit i high while requester i owns the mux.
- `Out_Valid` out 1: mux `Y` holds a newly loaded beat this cycle.
- `Busy` out 1: state is not IDLE.

## Operation
- States are IDLE and XFER.
  - IDLE: `Gnt`=0 and `Enable`=0.
  - If any `Req` bit is high, select the first set bit searching upward from `ptr`, with wrap-around 7→0.
  - Register `Sel` = that index, clear `beat_cnt`, go to XFER.
  - With no requests, stay in IDLE and hold `Sel`.
- XFER: `Gnt` = one-hot(`Sel`).
- Beat definition: `Enable` = XFER & `Req[Sel]` & `Out_Ready`, combinational from registered state and inputs.
- On each beat, `beat_cnt` increments.
- Burst end goes to IDLE with `ptr` = `Sel`+1 mod 8. A burst ends on any of:
  - a beat with `Last[Sel]`=1;
  - a beat with `beat_cnt`+1 == `MAX_BURST`;
  - `Req[Sel]`=0 in XFER. This ends the burst with no beat that cycle.
- `Out_Ready`=0 in XFER stalls: no beat, no count change, grant held, no timeout.
- `Out_Valid` is `Enable` delayed one cycle, matching the mux register latency.
- `Busy` = (state == XFER).
- Reset values:
  - state IDLE, `ptr`=0, `beat_cnt`=0;
  - `Sel`=0, `Gnt`=0, `Enable`=0, `Out_Valid`=0, `Busy`=0.
- `Reset` mid-burst: the burst is abandoned with no further `Enable`. `Out_Valid` still clears on the same edge, even if a beat was issued the cycle before.
- `beat_cnt` is 4 bits wide and never exceeds `MAX_BURST`-1.

## Timing
- Latency:
  - cycle 0: `Req` rises in IDLE;
  - cycle 1: XFER, `Gnt`, `Sel` valid, first possible `Enable`;
  - cycle 2: `Y` and `Out_Valid`.
- Peak throughput is 1 beat per cycle within a burst.
- Exactly one dead IDLE cycle follows every burst, including back-to-back grants to different requesters.
- `Sel` changes only on the IDLE→XFER edge, so it is stable for the whole burst.
- Requests arriving during XFER are not considered until the next IDLE cycle.
- The arbitration order is evaluated in IDLE against `ptr` only. A requester that just finished has the lowest priority next round.

## Structure
- Package `mux_ctrl_pkg` holds:
  - state enum (IDLE, XFER);
  - `NUM_REQ`, `SEL_W`, and the `BEAT_W`=4 constants.
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: `Req`[7:0], `ptr`[2:0].
  - Outputs: `idx`[2:0] and `any`.
  - It is reusable by other arbiters in the design.
- The top level holds the FSM, `ptr`, `beat_cnt`, `Sel`, and the `Out_Valid` flop. It instantiates no mux.

## Test plan
- Single burst, capped: `Req`=8'h04, `Last`=0, `Out_Ready`=1 → `Gnt`=8'h04 and `Sel`=2 at cycle 1. Four `Enable` beats, cycles 1–4. IDLE at cycle 5, `ptr`=3. `Out_Valid` high cycles 2–5.
- Round-robin fairness: `Req`=8'h81 held, `Last`=all 1 → grants alternate 0, 7, 0, 7. Each grant is 1 beat, separated by one IDLE cycle.
- Wrap-around: after a grant to 7, `Req`=8'h03 → next grant is to 0, not 1.
- Backpressure: grant to 5, `Out_Ready` low for 3 cycles mid-burst → no `Enable` and no `Out_Valid` during the stall. `Gnt`=8'h20 holds. The total beat count is still 4.
- Early terminations:
  - `Last[1]` on beat 2 → burst ends after 2 beats.
  - `Req[Sel]` dropped mid-burst → IDLE next cycle with no extra beat.
- `Reset` asserted in XFER after beat 2 → next cycle all outputs are 0, state IDLE, `ptr`=0. The next grant to 8'h10 starts cleanly with `Sel`=4.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the mux round-robin scheduler.
// Imported by the scheduler top level and the round-robin picker.
package mux_ctrl_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int BEAT_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr,
// wrapping from the top requester back to requester 0.
module rr_pick
    import mux_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] Req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand_s;

    assign any = |Req;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        idx    = {SEL_W{1'b0}};
        cand_s = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ptr + k[SEL_W-1:0];
            if (Req[cand_s]) begin
                idx = cand_s;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the shared 8:1 registered mux: picks one requester
// per burst, paces beats against downstream credit and qualifies the mux output.
module mux_rr_sched
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Last,
    input  logic               Out_Ready,
    output logic [SEL_W-1:0]   Sel,
    output logic               Enable,
    output logic [NUM_REQ-1:0] Gnt,
    output logic               Out_Valid,
    output logic               Busy
);

    localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(MAX_BURST - 1);

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   ptr_r, ptr_s;
    logic [SEL_W-1:0]   sel_r, sel_s;
    logic [BEAT_W-1:0]  beat_cnt_r, beat_cnt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_s;
    logic               out_valid_r;
    logic [SEL_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               enable_s;

    rr_pick u_rr_pick (
        .Req (Req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Reset abandons the burst immediately, so no beat is issued while it is held.
    assign enable_s = (state_r == XFER) & Req[sel_r] & Out_Ready & ~Reset;

    // Next-state logic: arbitration in IDLE, beat counting and burst termination in XFER.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        sel_s      = sel_r;
        beat_cnt_s = beat_cnt_r;
        gnt_s      = gnt_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s    = XFER;
                    sel_s      = pick_idx_s;
                    beat_cnt_s = {BEAT_W{1'b0}};
                    gnt_s      = onehot(pick_idx_s);
                end else begin
                    gnt_s = {NUM_REQ{1'b0}};
                end
            end
            XFER: begin
                if (!Req[sel_r] || (enable_s && (Last[sel_r] || beat_cnt_r == BURST_LAST))) begin
                    state_s    = IDLE;
                    ptr_s      = sel_r + 3'd1;
                    beat_cnt_s = {BEAT_W{1'b0}};
                    gnt_s      = {NUM_REQ{1'b0}};
                end else if (enable_s) begin
                    beat_cnt_s = beat_cnt_r + 4'd1;
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s    = IDLE;
                beat_cnt_s = {BEAT_W{1'b0}};
                gnt_s      = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State, arbitration pointer, select/grant and output-qualifier registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= IDLE;
            ptr_r       <= {SEL_W{1'b0}};
            sel_r       <= {SEL_W{1'b0}};
            beat_cnt_r  <= {BEAT_W{1'b0}};
            gnt_r       <= {NUM_REQ{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            sel_r       <= sel_s;
            beat_cnt_r  <= beat_cnt_s;
            gnt_r       <= gnt_s;
            out_valid_r <= enable_s;
        end
    end

    assign Sel       = sel_r;
    assign Gnt       = gnt_r;
    assign Enable    = enable_s;
    assign Out_Valid = out_valid_r;
    assign Busy      = (state_r == XFER);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: expected beat owners go into a scoreboard queue,
// a negedge monitor pops them on every Enable and checks Out_Valid timing.
module tb_mux_rr_sched;

    logic       Clock;
    logic       Reset;
    logic [7:0] Req;
    logic [7:0] Last;
    logic       Out_Ready;
    logic [2:0] Sel;
    logic       Enable;
    logic [7:0] Gnt;
    logic       Out_Valid;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    bit mon_on = 1'b0;
    bit ov_model = 1'b0;

    mux_rr_sched #(.MAX_BURST(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Req       (Req),
        .Last      (Last),
        .Out_Ready (Out_Ready),
        .Sel       (Sel),
        .Enable    (Enable),
        .Gnt       (Gnt),
        .Out_Valid (Out_Valid),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_beats(input logic [2:0] idx, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(idx);
    endtask

    // Out_Valid reference: the beat strobe one clock later, cleared by reset.
    always @(posedge Clock) ov_model <= Reset ? 1'b0 : Enable;

    // Monitor: every beat must belong to the next expected owner.
    always @(negedge Clock) begin
        logic [2:0] e;
        logic [7:0] one;
        if (mon_on) begin
            chk("out_valid", {31'd0, Out_Valid}, {31'd0, ov_model});
            if (Enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    one = 8'd1;
                    chk("beat_sel", {29'd0, Sel}, {29'd0, e});
                    chk("beat_gnt", {24'd0, Gnt}, {24'd0, one << e});
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; Req = 8'h00; Last = 8'h00; Out_Ready = 1'b1;
        step(); step();
        chk("rst_sel", {29'd0, Sel}, 32'd0);
        chk("rst_gnt", {24'd0, Gnt}, 32'd0);
        chk("rst_en", {31'd0, Enable}, 32'd0);
        chk("rst_ov", {31'd0, Out_Valid}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b0;
        mon_on = 1'b1;

        // Single capped burst to requester 2, then ptr=3 shows up as priority for 3 over 2.
        Req = 8'h04; push_beats(3'd2, 4);
        step();
        chk("t1_gnt", {24'd0, Gnt}, 32'h04);
        chk("t1_sel", {29'd0, Sel}, 32'd2);
        chk("t1_busy", {31'd0, Busy}, 32'd1);
        chk("t1_en_c1", {31'd0, Enable}, 32'd1);
        step();
        chk("t1_ov_c2", {31'd0, Out_Valid}, 32'd1);
        step(); step();
        chk("t1_en_c4", {31'd0, Enable}, 32'd1);
        step();
        chk("t1_idle_c5", {31'd0, Busy}, 32'd0);
        chk("t1_gnt_c5", {24'd0, Gnt}, 32'd0);
        chk("t1_ov_c5", {31'd0, Out_Valid}, 32'd1);
        Req = 8'h0C; Last = 8'hFF; push_beats(3'd3, 1);
        step();
        chk("t1_ptr3_sel", {29'd0, Sel}, 32'd3);
        step();
        chk("t1_end_busy", {31'd0, Busy}, 32'd0);
        Req = 8'h00;
        step();

        // Fairness and wrap-around (ptr=4 here): 7, 0, 7, then Req=03 grants 0.
        Req = 8'h81; push_beats(3'd7, 1); push_beats(3'd0, 1); push_beats(3'd7, 1);
        step(); chk("t2_g7a", {24'd0, Gnt}, 32'h80);
        step(); chk("t2_idle1", {31'd0, Busy}, 32'd0);
        step(); chk("t2_g0", {24'd0, Gnt}, 32'h01);
        step(); chk("t2_idle2", {31'd0, Busy}, 32'd0);
        step(); chk("t2_g7b", {24'd0, Gnt}, 32'h80);
        step(); chk("t2_idle3", {31'd0, Busy}, 32'd0);
        Req = 8'h03; push_beats(3'd0, 1);
        step(); chk("t3_wrap_sel", {29'd0, Sel}, 32'd0);
        step(); chk("t3_idle", {31'd0, Busy}, 32'd0);
        Req = 8'h00; Last = 8'h00;
        step();

        // Backpressure on requester 5 (ptr=1): two beats, 3-cycle stall, two beats.
        Req = 8'h20; push_beats(3'd5, 4);
        step(); chk("t4_gnt", {24'd0, Gnt}, 32'h20);
        step();
        step(); Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_en", {31'd0, Enable}, 32'd0);
            chk("t4_stall_ov", {31'd0, Out_Valid}, 32'd0);
            chk("t4_stall_gnt", {24'd0, Gnt}, 32'h20);
        end
        Out_Ready = 1'b1;
        step(); chk("t4_busy_b4", {31'd0, Busy}, 32'd1);
        step(); chk("t4_done", {31'd0, Busy}, 32'd0);
        Req = 8'h00;
        step();

        // Last[1] on beat 2 (ptr=6, so 1 wins after wrapping).
        Req = 8'h02; push_beats(3'd1, 2);
        step(); chk("t5_sel", {29'd0, Sel}, 32'd1);
        step(); Last = 8'h02;
        step(); chk("t5_done", {31'd0, Busy}, 32'd0);
        Req = 8'h00; Last = 8'h00;
        step();

        // Request dropped mid-burst (ptr=2): two beats then IDLE with no extra beat.
        Req = 8'h08; push_beats(3'd3, 2);
        step(); step();
        step(); chk("t6_busy_c3", {31'd0, Busy}, 32'd1);
        Req = 8'h00;
        step();
        chk("t6_idle", {31'd0, Busy}, 32'd0);
        chk("t6_no_en", {31'd0, Enable}, 32'd0);
        step();

        // Reset mid-burst after beat 2 (ptr=4, Req=06 picks 1).
        Req = 8'h06; push_beats(3'd1, 2);
        step(); step();
        step(); Reset = 1'b1; Out_Ready = 1'b0;
        step();
        chk("t7_rst_sel", {29'd0, Sel}, 32'd0);
        chk("t7_rst_gnt", {24'd0, Gnt}, 32'd0);
        chk("t7_rst_ov", {31'd0, Out_Valid}, 32'd0);
        chk("t7_rst_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b0; Out_Ready = 1'b1; Req = 8'h10; Last = 8'hFF; push_beats(3'd4, 1);
        step(); chk("t7_sel4", {29'd0, Sel}, 32'd4);
        Req = 8'h18;
        step(); chk("t7_idle", {31'd0, Busy}, 32'd0);
        push_beats(3'd3, 1);
        step(); chk("t7_ptr_sel3", {29'd0, Sel}, 32'd3);
        step(); Req = 8'h00;
        step(); step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
